// File: rtl/l2_port_arbiter.sv
// L2 port arbiter: shares one L2 cache port between I-cache and D-cache.
// Ports: clk/rst (async active-low), i_* (I-cache), d_* (D-cache), l2_* (L2).
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module l2_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic              l2_read_q, l2_read_d;
  logic              l2_write_q, l2_write_d;
  logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
  logic [DATA_W-1:0] l2_wdata_q, l2_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;
`ifdef ARB_ROUND_ROBIN_EN
  // 1 = I-cache served last, 0 = D-cache served last
  logic              last_grant_q, last_grant_d;
`endif

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the port not served last wins
  assign grant_d = d_req & (~i_read | last_grant_q);
`else
  assign grant_d = d_req;
`endif
  assign grant_i = i_read & ~grant_d;

  always_comb begin
    state_d    = state_q;
    l2_read_d  = l2_read_q;
    l2_write_d = l2_write_q;
    l2_addr_d  = l2_addr_q;
    l2_wdata_d = l2_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_ready_d  = i_ready_q;
    d_ready_d  = d_ready_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          l2_addr_d  = d_addr;
          l2_wdata_d = d_wdata;
          // write wins over an illegal read+write
          l2_write_d = d_write;
          l2_read_d  = ~d_write;
          state_d    = SERVE_D;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b0;
`endif
        end else if (grant_i) begin
          l2_addr_d = i_addr;
          l2_read_d = 1'b1;
          state_d   = SERVE_I;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b1;
`endif
        end
      end
      SERVE_I: begin
        if (l2_ready) begin
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
          i_rdata_d  = l2_rdata;
          i_ready_d  = 1'b1;
          state_d    = RELEASE;
        end
      end
      SERVE_D: begin
        if (l2_ready) begin
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
          if (l2_read_q) d_rdata_d = l2_rdata;
          d_ready_d  = 1'b1;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        // no grant here: the just-acked request may still be high
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      l2_read_q  <= l2_read_d;
      l2_write_q <= l2_write_d;
      l2_addr_q  <= l2_addr_d;
      l2_wdata_q <= l2_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign l2_read  = l2_read_q;
  assign l2_write = l2_write_q;
  assign l2_addr  = l2_addr_q;
  assign l2_wdata = l2_wdata_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign i_ready  = i_ready_q;
  assign d_ready  = d_ready_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed self-checking bench for l2_port_arbiter.
// Covers reset, I read, D write-back, ties, held request, mid-reset.
module tb_l2_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 0;
  logic          rst = 1;
  logic          i_read = 0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read = 0;
  logic          d_write = 0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_addr;
  logic [DW-1:0] l2_wdata;
  logic [DW-1:0] l2_rdata = '0;
  logic          l2_ready = 0;

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] DA5 = {16{8'hA5}};
  localparam logic [DW-1:0] DX1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DW-1:0] DX2 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
  localparam logic [DW-1:0] DX3 = 128'hDEAD_BEEF_0000_0000_CAFE_F00D_0000_0003;

  always #5 clk = ~clk;

  l2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .l2_read(l2_read), .l2_write(l2_write),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 0;
    tick();
    tick();
    checks++;
    if ({l2_read, l2_write, i_ready, d_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 0000",
               {l2_read, l2_write, i_ready, d_ready});
    end
    checks++;
    if ({l2_addr, l2_wdata, i_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h exp 0",
               l2_addr, l2_wdata, i_rdata, d_rdata);
    end
    rst = 1;
    tick();
  endtask

  task automatic test_single_i_read();
    i_read = 1;
    i_addr = 28'h10;
    tick();
    checks++;
    if ({l2_read, l2_write} !== 2'b10 || l2_addr !== 28'h10) begin
      errors++;
      $display("FAIL i_req: got rd=%b wr=%b addr=%h exp 1 0 10",
               l2_read, l2_write, l2_addr);
    end
    tick();
    tick();
    tick();
    checks++;
    if (i_ready !== 1'b0 || l2_read !== 1'b1) begin
      errors++;
      $display("FAIL i_wait: got rdy=%b rd=%b exp 0 1", i_ready, l2_read);
    end
    l2_ready = 1;
    l2_rdata = DA5;
    tick();
    l2_ready = 0;
    l2_rdata = '0;
    checks++;
    if (i_ready !== 1'b1 || i_rdata !== DA5 || l2_read !== 1'b0) begin
      errors++;
      $display("FAIL i_done: got rdy=%b data=%h rd=%b exp 1 %h 0",
               i_ready, i_rdata, l2_read, DA5);
    end
    i_read = 0;
    tick();
    checks++;
    if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL i_pulse: got i=%b d=%b exp 0 0", i_ready, d_ready);
    end
    tick();
  endtask

  task automatic test_d_writeback();
    d_write = 1;
    d_addr  = 28'h3F;
    d_wdata = 128'h1234;
    tick();
    checks++;
    if ({l2_read, l2_write} !== 2'b01 || l2_addr !== 28'h3F ||
        l2_wdata !== 128'h1234) begin
      errors++;
      $display("FAIL d_wr_req: got rd=%b wr=%b addr=%h wd=%h exp 0 1 3f 1234",
               l2_read, l2_write, l2_addr, l2_wdata);
    end
    l2_ready = 1;
    l2_rdata = DX3;
    tick();
    l2_ready = 0;
    checks++;
    if (d_ready !== 1'b1 || d_rdata !== '0 || l2_write !== 1'b0 ||
        l2_read !== 1'b0) begin
      errors++;
      $display("FAIL d_wr_done: got rdy=%b data=%h wr=%b rd=%b exp 1 0 0 0",
               d_ready, d_rdata, l2_write, l2_read);
    end
    d_write = 0;
    tick();
    checks++;
    if (d_ready !== 1'b0) begin
      errors++;
      $display("FAIL d_wr_pulse: got %b exp 0", d_ready);
    end
    tick();
  endtask

`ifndef ARB_ROUND_ROBIN_EN
  task automatic test_tie_fixed();
    i_read = 1;
    i_addr = 28'h20;
    d_read = 1;
    d_addr = 28'h30;
    tick();
    checks++;
    if (l2_read !== 1'b1 || l2_addr !== 28'h30) begin
      errors++;
      $display("FAIL tie_first: got rd=%b addr=%h exp 1 30", l2_read, l2_addr);
    end
    l2_ready = 1;
    l2_rdata = DX1;
    tick();
    l2_ready = 0;
    checks++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== DX1) begin
      errors++;
      $display("FAIL tie_d_done: got d=%b i=%b data=%h exp 1 0 %h",
               d_ready, i_ready, d_rdata, DX1);
    end
    d_read = 0;
    tick();
    checks++;
    if (d_ready !== 1'b0 || l2_read !== 1'b0) begin
      errors++;
      $display("FAIL tie_release: got d=%b rd=%b exp 0 0", d_ready, l2_read);
    end
    tick();
    checks++;
    if (l2_read !== 1'b1 || l2_addr !== 28'h20) begin
      errors++;
      $display("FAIL tie_second: got rd=%b addr=%h exp 1 20", l2_read, l2_addr);
    end
    l2_ready = 1;
    l2_rdata = DX2;
    tick();
    l2_ready = 0;
    checks++;
    if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== DX2) begin
      errors++;
      $display("FAIL tie_i_done: got i=%b d=%b data=%h exp 1 0 %h",
               i_ready, d_ready, i_rdata, DX2);
    end
    i_read = 0;
    tick();
    checks++;
    if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_end: got i=%b d=%b exp 0 0", i_ready, d_ready);
    end
    tick();
  endtask
`else
  task automatic test_tie_rr();
    int ni = 0;
    int nd = 0;
    int to;
    i_read = 1;
    i_addr = 28'h20;
    d_read = 1;
    d_addr = 28'h30;
    for (int k = 0; k < 6; k++) begin
      to = 0;
      while (l2_read !== 1'b1 && to < 20) begin
        tick();
        to++;
      end
      checks++;
      if (l2_read !== 1'b1) begin
        errors++;
        $display("FAIL rr_timeout: round %0d no l2_read", k);
      end
      checks++;
      if (l2_addr !== ((k % 2 == 0) ? 28'h20 : 28'h30)) begin
        errors++;
        $display("FAIL rr_order: round %0d got addr=%h exp %h", k, l2_addr,
                 (k % 2 == 0) ? 28'h20 : 28'h30);
      end
      l2_ready = 1;
      tick();
      l2_ready = 0;
      checks++;
      if ({i_ready, d_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_ready: round %0d got i=%b d=%b", k, i_ready, d_ready);
      end
      if (k % 2 == 0) begin
        ni++;
        i_read = 0;
      end else begin
        nd++;
        d_read = 0;
      end
      tick();
      if (ni < 3) i_read = 1;
      if (nd < 3) d_read = 1;
    end
    i_read = 0;
    d_read = 0;
    tick();
  endtask
`endif

  task automatic test_held_request();
    d_read = 1;
    d_addr = 28'h44;
    tick();
    checks++;
    if (l2_read !== 1'b1 || l2_addr !== 28'h44) begin
      errors++;
      $display("FAIL held_req: got rd=%b addr=%h exp 1 44", l2_read, l2_addr);
    end
    l2_ready = 1;
    l2_rdata = DX3;
    tick();
    l2_ready = 0;
    checks++;
    if (d_ready !== 1'b1 || d_rdata !== DX3) begin
      errors++;
      $display("FAIL held_done: got rdy=%b data=%h exp 1 %h",
               d_ready, d_rdata, DX3);
    end
    tick();
    d_read = 0;
    l2_ready = 1;
    tick();
    l2_ready = 0;
    checks++;
    if ({l2_read, l2_write, i_ready, d_ready} !== 4'b0) begin
      errors++;
      $display("FAIL held_regrant: got %b exp 0000",
               {l2_read, l2_write, i_ready, d_ready});
    end
    tick();
    checks++;
    if ({l2_read, i_ready, d_ready} !== 3'b0) begin
      errors++;
      $display("FAIL spurious_l2: got %b exp 000", {l2_read, i_ready, d_ready});
    end
  endtask

  task automatic test_reset_mid();
    d_read = 1;
    d_addr = 28'h55;
    tick();
    tick();
    tick();
    rst = 0;
    #1;
    checks++;
    if ({l2_read, l2_write, i_ready, d_ready} !== 4'b0 || l2_addr !== '0 ||
        d_rdata !== '0) begin
      errors++;
      $display("FAIL mid_reset: got ctl=%b addr=%h data=%h exp 0",
               {l2_read, l2_write, i_ready, d_ready}, l2_addr, d_rdata);
    end
    d_read = 0;
    tick();
    rst = 1;
    tick();
    tick();
    tick();
    checks++;
    if ({l2_read, l2_write, i_ready, d_ready} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b exp 0000",
               {l2_read, l2_write, i_ready, d_ready});
    end
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_d_writeback();
`ifndef ARB_ROUND_ROBIN_EN
    test_tie_fixed();
`else
    test_tie_rr();
`endif
    test_held_request();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
